// File: rtl/pwm_pkg.sv
// Shared width helpers and duty-to-threshold scaling for the PWM serializer.
package pwm_pkg;

    // Counter width able to hold 0..period-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned period);
        return (period > 1) ? 32'($clog2(period)) : 32'd1;
    endfunction

    // Width of the unshifted duty * period product.
    function automatic int unsigned prod_width(input int unsigned duty_bits,
                                               input int unsigned period);
        return duty_bits + 32'($clog2(period)) + 32'd1;
    endfunction

    // Scales a duty value to a counter threshold; result is always < period.
    function automatic longint unsigned duty_to_thresh(input longint unsigned duty,
                                                       input int unsigned     duty_bits,
                                                       input int unsigned     period);
        longint unsigned prod;
        prod = duty * 64'(period);
        return prod >> duty_bits;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/pending sample, period-aligned threshold and enable,
// sticky underrun flag and registered comparator output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned  DUTY_BITS     = 10,
    parameter int unsigned  PERIOD_CYCLES = 2000,
    localparam int unsigned CW            = cnt_width(PERIOD_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wrap_i,
    input  logic [CW-1:0]        cnt_i,
    input  logic                 we_i,
    input  logic [DUTY_BITS-1:0] duty_i,
    input  logic                 enable_i,
    input  logic                 clr_i,
    output logic                 pwm_o,
    output logic                 pending_o,
    output logic                 underrun_o
);

    logic [DUTY_BITS-1:0] shadow_q,    shadow_d;
    logic                 pending_q,   pending_d;
    logic [CW-1:0]        thresh_q,    thresh_d;
    logic                 en_active_q, en_active_d;
    logic                 underrun_q,  underrun_d;
    logic                 pwm_q,       pwm_d;

    // Next-state: sample capture, period-boundary update, underrun tracking.
    always_comb begin
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        thresh_d    = thresh_q;
        en_active_d = en_active_q;
        underrun_d  = underrun_q;

        if (clr_i) begin
            underrun_d = 1'b0;
        end

        if (wrap_i) begin
            en_active_d = enable_i;
            if (pending_q) begin
                thresh_d  = CW'(duty_to_thresh(64'(shadow_q), DUTY_BITS, PERIOD_CYCLES));
                pending_d = 1'b0;
            end else if (en_active_q) begin
                underrun_d = 1'b1;
            end
        end

        // we_i only fires when not pending, so a wrap-cycle write lands for the next wrap.
        if (we_i) begin
            shadow_d  = duty_i;
            pending_d = 1'b1;
        end

        pwm_d = en_active_q && (cnt_i < thresh_q);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            thresh_q    <= '0;
            en_active_q <= 1'b0;
            underrun_q  <= 1'b0;
            pwm_q       <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            thresh_q    <= thresh_d;
            en_active_q <= en_active_d;
            underrun_q  <= underrun_d;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm_o      = pwm_q;
    assign pending_o  = pending_q;
    assign underrun_o = underrun_q;

endmodule

// File: rtl/pwm_multi_serializer.sv
// Multi-channel PWM serializer: shared period counter, sample handshake and
// channel decode feeding NUM_CH independent glitch-free PWM channels.
module pwm_multi_serializer
    import pwm_pkg::*;
#(
    parameter int unsigned  NUM_CH        = 2,
    parameter int unsigned  DUTY_BITS     = 10,
    parameter int unsigned  PERIOD_CYCLES = 2000,
    localparam int unsigned CH_BITS       = (NUM_CH > 1) ? 32'($clog2(NUM_CH)) : 32'd1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [CH_BITS-1:0]   s_chan,
    input  logic [DUTY_BITS-1:0] s_duty,
    input  logic [NUM_CH-1:0]    enable,
    input  logic                 underrun_clr,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic                 period_start,
    output logic [NUM_CH-1:0]    underrun
);

    localparam int unsigned   CW      = cnt_width(PERIOD_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pstart_q, pstart_d;
    logic              wrap_c;
    logic [NUM_CH-1:0] pending_vec;
    logic [NUM_CH-1:0] we_c;

    assign wrap_c = (cnt_q == CNT_MAX);

    // Period counter and period_start pulse (aligned with the first output cycle).
    always_comb begin
        cnt_d    = wrap_c ? '0 : cnt_q + CW'(1);
        pstart_d = (cnt_q == '0);
    end

    // Counter and period_start registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            pstart_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pstart_q <= pstart_d;
        end
    end

    assign period_start = pstart_q;

    // Ready mux and write decode; out-of-range channels are always ready and dropped.
    always_comb begin
        s_ready = 1'b1;
        we_c    = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (s_chan == CH_BITS'(i)) begin
                s_ready = !pending_vec[i];
            end
        end
        for (int i = 0; i < int'(NUM_CH); i++) begin
            we_c[i] = s_valid && s_ready && (s_chan == CH_BITS'(i));
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        pwm_channel #(
            .DUTY_BITS     (DUTY_BITS),
            .PERIOD_CYCLES (PERIOD_CYCLES)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .wrap_i     (wrap_c),
            .cnt_i      (cnt_q),
            .we_i       (we_c[g]),
            .duty_i     (s_duty),
            .enable_i   (enable[g]),
            .clr_i      (underrun_clr),
            .pwm_o      (pwm_out[g]),
            .pending_o  (pending_vec[g]),
            .underrun_o (underrun[g])
        );
    end

endmodule
